// File: rtl/uart_distance_stats.sv
// Distance-sensor link: UART packet in -> min/max/mean -> 8-byte UART result frame out.
// Optional macro DIST_ZERO_FILTER_EN excludes zero-valued samples from the statistics.
module uart_distance_stats #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR0         = 8'hAA,
    parameter logic [7:0]  HDR1         = 8'h55
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic txd
);
    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HUNT0, P_HUNT1, P_LEN, P_LO, P_HI, P_DONE, P_DIV} p_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    rx_state_t      r_rx_state;
    logic           r_rx_s1, r_rx_s2, r_rx_prev;
    logic [CW-1:0]  r_rx_cnt;
    logic [2:0]     r_rx_bit;
    logic [7:0]     r_rx_shift;
    logic           r_rx_valid, r_rx_ferr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        r_rx_valid <= r_rx_s2;
                        r_rx_ferr  <= !r_rx_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    p_state_t       r_p_state;
    logic [7:0]     r_remaining, r_lo, r_count;
    logic [15:0]    r_min, r_max;
    logic [23:0]    r_sum;
    logic [4:0]     r_div_cnt;
    logic [7:0]     r_div_rem;
    logic [23:0]    r_div_quo;
    logic           r_res_valid;
    logic [15:0]    r_res_min, r_res_max, r_res_mean;

    logic [15:0]    w_sample;
    logic           w_sample_ok;
    logic [8:0]     w_div_shift;
    logic           w_div_ge;
    logic [7:0]     w_div_sub;

    assign w_sample    = {r_rx_shift, r_lo};
`ifdef DIST_ZERO_FILTER_EN
    assign w_sample_ok = (w_sample != 16'h0000);
`else
    assign w_sample_ok = 1'b1;
`endif
    // Partial remainder is always below the divisor, so the 8-bit wrap of the subtraction is exact.
    assign w_div_shift = {r_div_rem, r_div_quo[23]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_count});
    assign w_div_sub   = w_div_shift[7:0] - r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_state   <= P_HUNT0;
            r_remaining <= '0;
            r_lo        <= '0;
            r_count     <= '0;
            r_min       <= 16'hFFFF;
            r_max       <= '0;
            r_sum       <= '0;
            r_div_cnt   <= '0;
            r_div_rem   <= '0;
            r_div_quo   <= '0;
            r_res_valid <= 1'b0;
            r_res_min   <= '0;
            r_res_max   <= '0;
            r_res_mean  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_p_state)
                P_HUNT0: if (r_rx_valid && r_rx_shift == HDR0) r_p_state <= P_HUNT1;
                P_HUNT1: begin
                    if (r_rx_valid) begin
                        if (r_rx_shift == HDR1)      r_p_state <= P_LEN;
                        else if (r_rx_shift != HDR0) r_p_state <= P_HUNT0;
                    end
                end
                P_LEN: begin
                    if (r_rx_valid) begin
                        if (r_rx_shift == 8'd0) begin
                            r_p_state <= P_HUNT0;
                        end else begin
                            r_remaining <= r_rx_shift;
                            r_min       <= 16'hFFFF;
                            r_max       <= '0;
                            r_sum       <= '0;
                            r_count     <= '0;
                            r_p_state   <= P_LO;
                        end
                    end
                end
                P_LO: begin
                    if (r_rx_valid) begin
                        r_lo      <= r_rx_shift;
                        r_p_state <= P_HI;
                    end
                end
                P_HI: begin
                    if (r_rx_valid) begin
                        if (w_sample_ok) begin
                            if (w_sample < r_min) r_min <= w_sample;
                            if (w_sample > r_max) r_max <= w_sample;
                            r_sum   <= r_sum + {8'd0, w_sample};
                            r_count <= r_count + 8'd1;
                        end
                        r_remaining <= r_remaining - 8'd1;
                        r_p_state   <= (r_remaining == 8'd1) ? P_DONE : P_LO;
                    end
                end
                P_DONE: begin
                    if (r_count == 8'd0) begin
                        r_res_min   <= '0;
                        r_res_max   <= '0;
                        r_res_mean  <= '0;
                        r_res_valid <= 1'b1;
                        r_p_state   <= P_HUNT0;
                    end else begin
                        r_div_rem <= '0;
                        r_div_quo <= r_sum;
                        r_div_cnt <= 5'd24;
                        r_p_state <= P_DIV;
                    end
                end
                default: begin
                    if (r_div_cnt == 5'd0) begin
                        r_res_min   <= r_min;
                        r_res_max   <= r_max;
                        r_res_mean  <= r_div_quo[15:0];
                        r_res_valid <= 1'b1;
                        r_p_state   <= P_HUNT0;
                    end else begin
                        r_div_rem <= w_div_ge ? w_div_sub : w_div_shift[7:0];
                        r_div_quo <= {r_div_quo[22:0], w_div_ge};
                        r_div_cnt <= r_div_cnt - 5'd1;
                    end
                end
            endcase
            // A framing error abandons any packet being assembled.
            if (r_rx_ferr && r_p_state != P_DONE && r_p_state != P_DIV)
                r_p_state <= P_HUNT0;
        end
    end

    tx_state_t      r_tx_state;
    logic [CW-1:0]  r_tx_cnt;
    logic [2:0]     r_tx_bit, r_tx_byte;
    logic [63:0]    r_tx_data;
    logic           r_txd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_data  <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                    if (r_res_valid) begin
                        r_tx_data  <= {r_res_mean, r_res_max, r_res_min, HDR1, HDR0};
                        r_tx_byte  <= '0;
                        r_tx_cnt   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_data[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt  <= '0;
                        r_tx_data <= r_tx_data >> 1;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_txd    <= r_tx_data[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_byte == 3'd7) begin
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_byte  <= r_tx_byte + 3'd1;
                            r_txd      <= 1'b0;
                            r_tx_state <= TX_START;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign txd = r_txd;

endmodule

// File: tb/tb_uart_distance_stats.sv
// Directed bench for uart_distance_stats: table of packets with hand-computed result frames,
// plus reset, latency and back-to-back timing sequences.
module tb_uart_distance_stats;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1;
    logic txd;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    uart_distance_stats #(
        .CLKS_PER_BIT(CPB),
        .HDR0(8'hAA),
        .HDR1(8'h55)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .txd(txd)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] rx_q[$];
    int start_q[$];
    int stop_errs = 0;
    int last_stop = 0;

    // Decode the txd line into bytes, recording the cycle each start bit was seen.
    initial begin : mon
        logic prev;
        logic [7:0] b;
        int t0;
        prev = 1'b1;
        b = '0;
        forever begin
            @(negedge clk);
            if (prev && !txd) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (!txd) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = txd;
                    end
                    repeat (CPB) @(negedge clk);
                    if (!txd) stop_errs++;
                    rx_q.push_back(b);
                    start_q.push_back(t0);
                end
            end
            prev = txd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) tick();
        end
        rxd = stop_ok;
        last_stop = cyc;
        repeat (CPB) tick();
        rxd = 1'b1;
        if (!stop_ok) repeat (2 * CPB) tick();
    endtask

    typedef struct {
        int               n_in;
        logic [0:11][7:0] in_b;
        int               bad_idx;
        int               n_exp;
        logic [0:7][7:0]  exp_b;
    } vec_t;

    vec_t tbl[10];

    initial begin : main
        int lows;
        int lat;
        int waited;

        tbl[0] = '{9, {8'hAA,8'h55,8'h03,8'h0A,8'h00,8'h14,8'h00,8'h06,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h06,8'h00,8'h14,8'h00,8'h0C,8'h00}};
        tbl[1] = '{7, {8'hAA,8'h55,8'h02,8'hFF,8'hFF,8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF}};
        tbl[2] = '{8, {8'hAA,8'h55,8'h00,8'hAA,8'h55,8'h01,8'h34,8'h12,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h34,8'h12,8'h34,8'h12,8'h34,8'h12}};
        tbl[3] = '{6, {8'hAA,8'hAA,8'h55,8'h01,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h05,8'h00,8'h05,8'h00,8'h05,8'h00}};
        tbl[4] = '{7, {8'hAA,8'h55,8'h02,8'h0A,8'h00,8'h0B,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 5, 0,
                   {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};
        tbl[5] = '{5, {8'hAA,8'h55,8'h01,8'h07,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h07,8'h00,8'h07,8'h00,8'h07,8'h00}};
`ifdef DIST_ZERO_FILTER_EN
        tbl[6] = '{9, {8'hAA,8'h55,8'h03,8'h00,8'h00,8'h08,8'h00,8'h04,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h04,8'h00,8'h08,8'h00,8'h06,8'h00}};
`else
        tbl[6] = '{9, {8'hAA,8'h55,8'h03,8'h00,8'h00,8'h08,8'h00,8'h04,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h00,8'h00,8'h08,8'h00,8'h04,8'h00}};
`endif
        tbl[7] = '{5, {8'hAA,8'h55,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}};
        tbl[8] = '{7, {8'hAA,8'h55,8'h02,8'h01,8'h00,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'h01,8'h00,8'h02,8'h00,8'h01,8'h00}};
        tbl[9] = '{9, {8'hAA,8'h55,8'h03,8'h00,8'h80,8'h00,8'h80,8'hFF,8'h7F,8'h00,8'h00,8'h00}, -1, 1,
                   {8'hAA,8'h55,8'hFF,8'h7F,8'h00,8'h80,8'hFF,8'h7F}};

        // Reset state and idle line
        reset = 1'b1;
        repeat (4) tick();
        chk("reset_txd", int'(txd), 1);
        reset = 1'b0;
        lows = 0;
        repeat (50) begin
            tick();
            if (txd !== 1'b1) lows++;
        end
        chk("idle_txd_low_cycles", lows, 0);
        $display("reset: txd=%0b idle_low_cycles=%0d", txd, lows);

        for (int v = 0; v < 10; v++) begin
            rx_q.delete();
            start_q.delete();
            for (int i = 0; i < tbl[v].n_in; i++)
                send_byte(tbl[v].in_b[i], i != tbl[v].bad_idx);
            repeat (100 * CPB) tick();
            $display("vec %0d: sent %0d bytes, received %0d bytes", v, tbl[v].n_in, rx_q.size());
            chk($sformatf("vec%0d_frame_bytes", v), rx_q.size(), 8 * tbl[v].n_exp);
            if (tbl[v].n_exp == 1 && rx_q.size() == 8) begin
                for (int i = 0; i < 8; i++)
                    chk($sformatf("vec%0d_byte%0d", v, i), int'(rx_q[i]), int'(tbl[v].exp_b[i]));
                lat = start_q[0] - last_stop;
                chk($sformatf("vec%0d_latency_in_window(%0d)", v, lat),
                    int'(lat >= CPB/2 + 3 + 24 && lat <= CPB/2 + 3 + 32), 1);
                chk($sformatf("vec%0d_frame_span", v), start_q[7] - start_q[0], 70 * CPB);
            end
        end

        // Reset in the middle of a packet: the tail must not complete a frame
        rx_q.delete();
        start_q.delete();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h0A, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (100 * CPB) tick();
        $display("mid-packet reset: received %0d bytes", rx_q.size());
        chk("midpkt_reset_no_frame", rx_q.size(), 0);

        // Reset in the middle of transmission: txd high next clock, no resumption
        rx_q.delete();
        start_q.delete();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h00, 1'b1);
        waited = 0;
        while (rx_q.size() < 2 && waited < 40 * CPB) begin
            tick();
            waited++;
        end
        chk("midtx_started", int'(rx_q.size() >= 2), 1);
        reset = 1'b1;
        tick();
        chk("midtx_txd_after_reset", int'(txd), 1);
        reset = 1'b0;
        repeat (20 * CPB) tick();
        rx_q.delete();
        start_q.delete();
        repeat (100 * CPB) tick();
        $display("mid-tx reset: txd=%0b, bytes after abort=%0d", txd, rx_q.size());
        chk("midtx_no_resume", rx_q.size(), 0);

        chk("tx_stop_bit_errors", stop_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
